axil_sram_responder: RTL

- Synthesizable AXI4-lite responder (slave) that terminates the nanorv32_axi memory port.
- Provides byte-strobed word SRAM plus a sticky "tests passed" status register.
- Independent AW/W acceptance and configurable read wait states stress the core's initiator handshakes on FPGA and in simulation.

---
 rtl/axil_sram_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/axil_sram_responder.sv
// AXI4-lite responder terminating the nanorv32_axi memory port.
// Byte-strobed word SRAM, a sticky "tests passed" flag written through a
// magic address, independent AW/W buffering and programmable read latency.
module axil_sram_responder #(
    parameter int          MEM_WORDS  = 16384,
    parameter int          READ_WAIT  = 0,
    parameter logic [31:0] PASS_ADDR  = 32'h2300_0000,
    parameter logic [31:0] PASS_VALUE = 32'd123456789
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        tests_passed,
    output logic        decode_err
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] WORDS     = 32'(MEM_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(READ_WAIT);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

    // A byte address maps to SRAM when its word index is below MEM_WORDS.
    function automatic logic in_sram(input logic [31:0] addr);
        return {2'b00, addr[31:2]} < WORDS;
    endfunction

    logic [31:0] mem [MEM_WORDS];

    // Protection bits carry no meaning for this responder.
    logic unused_prot;
    assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

    // ---------------------------------------------------------------- write
    logic        aw_full, w_full, aw_full_d, w_full_d;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;
    logic        aw_hs, w_hs, commit;
    logic        wr_pass, wr_sram;

    assign aw_hs   = mem_axi_awvalid & mem_axi_awready;
    assign w_hs    = mem_axi_wvalid & mem_axi_wready;
    // A commit needs both halves buffered and the response channel free.
    assign commit  = aw_full & w_full & ~mem_axi_bvalid;
    assign wr_pass = (aw_addr == PASS_ADDR);
    assign wr_sram = !wr_pass && in_sram(aw_addr);

    // Next buffer occupancy: a commit drains, a handshake (only when empty) fills.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        aw_full_d = aw_full;
        w_full_d  = w_full;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) aw_full_d = 1'b1;
        if (w_hs)  w_full_d  = 1'b1;
    end

    // Buffer registers, registered readys, write response and pass flag.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
        if (!resetn) begin
            aw_full         <= 1'b0;
            w_full          <= 1'b0;
            mem_axi_awready <= 1'b0;
            mem_axi_wready  <= 1'b0;
            mem_axi_bvalid  <= 1'b0;
            aw_addr         <= '0;
            w_data          <= '0;
            w_strb          <= '0;
            tests_passed    <= 1'b0;
        end else begin
            aw_full         <= aw_full_d;
            w_full          <= w_full_d;
            mem_axi_awready <= !aw_full_d;
            mem_axi_wready  <= !w_full_d;
            if (aw_hs) aw_addr <= mem_axi_awaddr;
            if (w_hs) begin
                w_data <= mem_axi_wdata;
                w_strb <= mem_axi_wstrb;
            end
            if (commit)              mem_axi_bvalid <= 1'b1;
            else if (mem_axi_bready) mem_axi_bvalid <= 1'b0;
            if (commit && wr_pass && (w_data == PASS_VALUE) && (w_strb == 4'hF))
                tests_passed <= 1'b1;
        end
    end

    // Byte-lane SRAM write on commit.
    // NOTE: the SRAM array is deliberately not reset; it lives in its own reset-free process so it can map to block RAM.
    always_ff @(posedge clk) begin
        if (commit && wr_sram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[aw_addr[IDX_W+1:2]][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_t   rd_state, rd_state_d;
    logic [3:0]  rd_cnt;
    logic [31:0] rd_addr, rd_word;
    logic        ar_take, r_load, cnt_dec;
    logic        rd_pass, rd_sram;

    assign rd_pass = (rd_addr == PASS_ADDR);
    assign rd_sram = !rd_pass && in_sram(rd_addr);

    // Read FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_state <= RD_IDLE;
        else         rd_state <= rd_state_d;
    end

    // Read FSM next state.
    always_comb begin
        rd_state_d = rd_state;
        case (rd_state)
            RD_IDLE: if (mem_axi_arvalid && mem_axi_arready) rd_state_d = RD_WAIT;
            RD_WAIT: if (rd_cnt == 4'd0)                     rd_state_d = RD_RESP;
            RD_RESP: if (mem_axi_rready)                     rd_state_d = RD_IDLE;
            default:                                         rd_state_d = RD_IDLE;
        endcase
    end

    // Read FSM control strobes.
    always_comb begin
        ar_take = 1'b0;
        r_load  = 1'b0;
        cnt_dec = 1'b0;
        case (rd_state)
            RD_IDLE: ar_take = mem_axi_arvalid & mem_axi_arready;
            RD_WAIT: begin
                r_load  = (rd_cnt == 4'd0);
                cnt_dec = (rd_cnt != 4'd0);
            end
            default: ;
        endcase
    end

    // Read source select; SRAM is sampled before any same-edge commit lands.
    always_comb begin
        rd_word = '0;
        if (rd_pass)      rd_word = {31'b0, tests_passed};
        else if (rd_sram) rd_word = mem[rd_addr[IDX_W+1:2]];
    end

    // Read datapath: address latch, wait counter, registered arready/rvalid/rdata.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_arready <= 1'b0;
            mem_axi_rvalid  <= 1'b0;
            mem_axi_rdata   <= '0;
            rd_addr         <= '0;
            rd_cnt          <= '0;
        end else begin
            mem_axi_arready <= (rd_state_d == RD_IDLE);
            mem_axi_rvalid  <= (rd_state_d == RD_RESP);
            if (ar_take) begin
                rd_addr <= mem_axi_araddr;
                rd_cnt  <= WAIT_LOAD;
            end else if (cnt_dec) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (r_load) mem_axi_rdata <= rd_word;
        end
    end

    // Sticky decode error from either path touching an unmapped address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            decode_err <= 1'b0;
        else if ((commit && !wr_pass && !wr_sram) || (r_load && !rd_pass && !rd_sram))
            decode_err <= 1'b1;
    end

endmodule
